// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Five-channel push-button conditioner that feeds the tone/beeper stage. Each
// raw, bouncing, active-low key is synchronised into clk and then debounced
// on its own. No channel depends on another.
//
// Ports
//   clk          system clock (single domain)
//   rst_n        synchronous active-low reset
//   key[4:0]     raw active-low buttons, asynchronous to clk
//   key_state    debounced active-low levels, registered
//   key_press    one-cycle pulse when key_state[i] is accepted going 1->0
//   key_release  one-cycle pulse when key_state[i] is accepted going 0->1
//   led          per-key toggle; bit i inverts on every key_press[i]
//
// Latency: a new level that is held stable and first sampled at edge E0
// appears on key_state at E0 + DEBOUNCE_CYCLES + 1. That is two synchroniser
// edges plus DEBOUNCE_CYCLES-1 counting edges. The accepting edge is the
// DEBOUNCE_CYCLES-th consecutive mismatch.
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key,
   output logic [4:0] key_state,
   output logic [4:0] key_press,
   output logic [4:0] key_release,
   output logic [4:0] led
);

   localparam int unsigned NUM_KEYS = 5;

   // The last count value before a mismatching level is accepted.
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [CNT_W-1:0]    cnt [NUM_KEYS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1       <= '1;
         sync2       <= '1;
         key_state   <= '1;
         key_press   <= '0;
         key_release <= '0;
         led         <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= key;
         sync2 <= sync1;

         // Pulses default low. They are raised only at an accepting edge.
         key_press   <= '0;
         key_release <= '0;

         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2[i] == key_state[i]) begin
               // Any matching sample restarts the qualification window.
               cnt[i] <= '0;
            end else if (cnt[i] != CNT_TC) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end else begin
               // The counter never passes CNT_TC. It clears at acceptance,
               // so it cannot wrap.
               cnt[i]       <= '0;
               key_state[i] <= sync2[i];
               if (!sync2[i]) begin
                  key_press[i] <= 1'b1;
                  led[i]       <= ~led[i];
               end else begin
                  key_release[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8 and CNT_W=4.
// The whole output bundle {key_state, key_press, key_release, led} is compared
// against hand-derived values one cycle at a time.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// Step n therefore covers edge E(n-1), taking the edge right after an input
// change as E0. An accepted level shows up after step 10, which is E0+9.
// -----------------------------------------------------------------------------
module tb_key_debounce;

   logic       clk;
   logic       rst_n;
   logic [4:0] key;
   logic [4:0] key_state;
   logic [4:0] key_press;
   logic [4:0] key_release;
   logic [4:0] led;

   int n_checks;
   int n_fail;

   logic [19:0] obs;
   logic [19:0] exp;

   key_debounce #(
      .DEBOUNCE_CYCLES(8),
      .CNT_W          (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .key_state  (key_state),
      .key_press  (key_press),
      .key_release(key_release),
      .led        (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {key_state, key_press, key_release, led};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      key   = 5'h1f;
      rst_n = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      n_checks++;
      if (obs !== {5'h1f, 5'h00, 5'h00, 5'h00}) begin
         n_fail++;
         $display("FAIL do_reset got=%h exp=%h", obs, {5'h1f, 15'h0});
      end
   endtask

   task automatic test_reset;
      key   = 5'b00000;
      rst_n = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         step;
         exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs, exp);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         step;
         if (e < 10)       exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         else if (e == 10) exp = {5'h00, 5'h1f, 5'h00, 5'h1f};
         else              exp = {5'h00, 5'h00, 5'h00, 5'h1f};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_release e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   task automatic test_clean_press;
      do_reset;
      key = 5'b11011;
      for (int e = 1; e <= 10; e++) begin
         step;
         exp = (e < 10) ? {5'h1f, 5'h00, 5'h00, 5'h00}
                        : {5'b11011, 5'b00100, 5'h00, 5'b00100};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL clean_press e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      for (int e = 1; e <= 10; e++) begin
         step;
         exp = {5'b11011, 5'h00, 5'h00, 5'b00100};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL clean_held e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      key = 5'h1f;
      for (int e = 1; e <= 11; e++) begin
         step;
         if (e < 10)       exp = {5'b11011, 5'h00, 5'h00, 5'b00100};
         else if (e == 10) exp = {5'h1f, 5'h00, 5'b00100, 5'b00100};
         else              exp = {5'h1f, 5'h00, 5'h00, 5'b00100};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL clean_release e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   task automatic test_glitch;
      do_reset;
      // 7 sampled low edges: must be rejected
      key = 5'b11110;
      for (int e = 1; e <= 20; e++) begin
         step;
         if (e == 7) key = 5'h1f;
         exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL glitch7 e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      // 8 sampled low edges: minimum accepted pulse
      key = 5'b11110;
      for (int e = 1; e <= 10; e++) begin
         step;
         if (e == 8) key = 5'h1f;
         exp = (e < 10) ? {5'h1f, 5'h00, 5'h00, 5'h00}
                        : {5'b11110, 5'b00001, 5'h00, 5'b00001};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL glitch8 e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   task automatic test_bounce;
      do_reset;
      for (int c = 0; c < 30; c++) begin
         key = ((c / 3) % 2 == 0) ? 5'b01111 : 5'h1f;
         step;
         exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL bounce_phase c=%0d got=%h exp=%h", c, obs, exp);
         end
      end
      key = 5'b01111;
      for (int e = 1; e <= 14; e++) begin
         step;
         if (e < 10)       exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         else if (e == 10) exp = {5'b01111, 5'b10000, 5'h00, 5'b10000};
         else              exp = {5'b01111, 5'h00, 5'h00, 5'b10000};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL bounce_settle e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   task automatic test_simultaneous;
      do_reset;
      key = 5'b10101;
      for (int e = 1; e <= 10; e++) begin
         step;
         exp = (e < 10) ? {5'h1f, 5'h00, 5'h00, 5'h00}
                        : {5'b10101, 5'b01010, 5'h00, 5'b01010};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL simul_press e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      key = 5'b10111;
      for (int e = 1; e <= 10; e++) begin
         step;
         exp = (e < 10) ? {5'b10101, 5'h00, 5'h00, 5'b01010}
                        : {5'b10111, 5'h00, 5'b00010, 5'b01010};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL simul_rel1 e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      key = 5'b10101;
      for (int e = 1; e <= 11; e++) begin
         step;
         if (e < 10)       exp = {5'b10111, 5'h00, 5'h00, 5'b01010};
         else if (e == 10) exp = {5'b10101, 5'b00010, 5'h00, 5'b01000};
         else              exp = {5'b10101, 5'h00, 5'h00, 5'b01000};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL simul_repress e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid_count;
      do_reset;
      key = 5'b11110;
      for (int e = 1; e <= 5; e++) begin
         step;
         exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL midrst_pre e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         step;
         if (e < 10)       exp = {5'h1f, 5'h00, 5'h00, 5'h00};
         else if (e == 10) exp = {5'b11110, 5'b00001, 5'h00, 5'b00001};
         else              exp = {5'b11110, 5'h00, 5'h00, 5'b00001};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL midrst_post e=%0d got=%h exp=%h", e, obs, exp);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      key      = 5'h1f;
      test_reset;
      test_clean_press;
      test_glitch;
      test_bounce;
      test_simultaneous;
      test_reset_mid_count;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
